acc_bank: RTL and testbench

- Multi-channel signed accumulator bank; parametrised successor of the single-register accumulator in the DSP datapath.
- Holds N independent W-bit accumulators, each updated by an opcode over a valid/ready input handshake.
- Includes a dump state machine that streams every channel out over a valid/ready output port, with optional clear-after-dump.
- Sits between the MAC/filter datapath and the result collector.

---
 rtl/dsp_acc_pkg.sv | 11 +
 rtl/acc_alu.sv | 33 +++
 rtl/acc_bank.sv | 74 +++++++
 tb/tb_acc_bank.sv | 135 +++++++++++++
 4 files changed

// File: rtl/dsp_acc_pkg.sv
// dsp_acc_pkg: opcodes and FSM state encoding for the accumulator bank
package dsp_acc_pkg;
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_LOAD = 3'd3;
  localparam logic [2:0] OP_ABS  = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;
  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_DUMP = 1'b1;
endpackage

// File: rtl/acc_alu.sv
// acc_alu: combinational signed accumulator update with overflow detection
// ACC_BANK_SATURATE_EN clamps overflowing results instead of wrapping
module acc_alu import dsp_acc_pkg::*; #(
  parameter int W = 32
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] acc,
  input  logic [W-1:0] operand,
  output logic [W-1:0] nxt,
  output logic         ovf
);
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX = {1'b0, {(W-1){1'b1}}};
  logic [W-1:0] sum, dif, raw;
  always_comb begin
    sum = acc + operand;
    dif = acc - operand;
    raw = op == OP_ADD  ? sum :
          op == OP_SUB  ? dif :
          op == OP_LOAD ? operand :
          op == OP_ABS  ? (acc[W-1] ? -acc : acc) :
          op == OP_CLR  ? '0 : acc;
    ovf = op == OP_ADD ? (acc[W-1] == operand[W-1] && sum[W-1] != acc[W-1]) :
          op == OP_SUB ? (acc[W-1] != operand[W-1] && dif[W-1] != acc[W-1]) :
          op == OP_ABS && acc == MIN;
`ifdef ACC_BANK_SATURATE_EN
    // the sign of the old value tells which rail an overflow ran into
    nxt = !ovf ? raw : op == OP_ABS ? MAX : acc[W-1] ? MIN : MAX;
`else
    nxt = raw;
`endif
  end
endmodule

// File: rtl/acc_bank.sv
// acc_bank: N-channel signed accumulator bank with streaming dump FSM
// optional ACC_BANK_SATURATE_EN selects saturating instead of wrapping arithmetic
module acc_bank import dsp_acc_pkg::*; #(
  parameter int W = 32,
  parameter int N = 4,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_ch,
  input  logic [2:0]    in_op,
  input  logic [W-1:0]  in_data,
  input  logic          dump,
  input  logic          dump_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_ch,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  output logic [N-1:0]  ovf,
  output logic          busy
);
  logic [0:0]   state;
  logic         clr_pend;
  logic [W-1:0] acc [N];
  logic [W-1:0] alu_nxt;
  logic         alu_ovf, xfer, clr_op, last_hs;
  acc_alu #(.W(W)) u_alu (
    .op(in_op),
    .acc(acc[in_ch]),
    .operand(in_data),
    .nxt(alu_nxt),
    .ovf(alu_ovf)
  );
  assign in_ready  = state == ST_ACC;
  assign out_valid = state == ST_DUMP;
  assign busy      = out_valid;
  assign out_last  = out_valid && out_ch == CW'(N-1);
  assign out_data  = acc[out_ch];
  assign xfer      = in_valid && in_ready;
  assign clr_op    = in_op == OP_LOAD || in_op == OP_CLR;
  assign last_hs   = out_last && out_ready;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_ACC;
      out_ch   <= '0;
      clr_pend <= 1'b0;
      ovf      <= '0;
      for (int i = 0; i < N; i++) acc[i] <= '0;
    end else begin
      if (xfer) begin
        acc[in_ch] <= alu_nxt;
        ovf[in_ch] <= !clr_op && (ovf[in_ch] || alu_ovf);
      end
      if (state == ST_ACC && dump) begin
        state    <= ST_DUMP;
        out_ch   <= '0;
        clr_pend <= dump_clr;
      end else if (last_hs) begin
        state    <= ST_ACC;
        out_ch   <= '0;
        clr_pend <= 1'b0;
        if (clr_pend) begin
          ovf <= '0;
          for (int i = 0; i < N; i++) acc[i] <= '0;
        end
      end else if (out_valid && out_ready) begin
        out_ch <= out_ch + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_acc_bank.sv
// tb_acc_bank: directed self-checking bench for acc_bank at W=8, N=4
module tb_acc_bank;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0, in_ready;
  logic [1:0] in_ch = '0;
  logic [2:0] in_op = '0;
  logic [7:0] in_data = '0;
  logic       dump = 1'b0, dump_clr = 1'b0;
  logic       out_valid, out_ready = 1'b0, out_last, busy;
  logic [1:0] out_ch;
  logic [7:0] out_data;
  logic [3:0] ovf;
  int n_cmp = 0, n_err = 0;
`ifdef ACC_BANK_SATURATE_EN
  localparam logic [7:0] E_ADD = 8'h7F, E_ABS = 8'h7F, E_SUB = 8'h80, E_ADD2 = 8'h7F;
`else
  localparam logic [7:0] E_ADD = 8'h82, E_ABS = 8'h80, E_SUB = 8'h7F, E_ADD2 = 8'hA5;
`endif
  acc_bank #(.W(8), .N(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_op(in_op), .in_data(in_data),
    .dump(dump), .dump_clr(dump_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
    .out_last(out_last), .ovf(ovf), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_op(input logic [1:0] ch, input logic [2:0] op, input logic [7:0] d);
    in_valid = 1'b1; in_ch = ch; in_op = op; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic run_dump(input logic clr, input logic [7:0] e0, e1, e2, e3,
                          input logic stall, input logic repulse);
    logic [7:0] e [4];
    int k, cyc, busy_n;
    e = '{e0, e1, e2, e3};
    dump = 1'b1; dump_clr = clr;
    @(posedge clk); #1;
    dump = 1'b0; dump_clr = 1'b0; in_valid = 1'b0;
    k = 0; cyc = 0; busy_n = 0;
    while (k < 4 && cyc < 40) begin
      out_ready = stall ? (cyc % 3 == 0) : 1'b1;
      dump = repulse && cyc == 1;
      chk("out_valid", out_valid, 1);
      chk("in_ready_dump", in_ready, 0);
      chk("out_ch", out_ch, k);
      chk("out_data", out_data, e[k]);
      chk("out_last", out_last, k == 3);
      busy_n += busy;
      @(posedge clk); #1;
      if (out_ready) k++;
      cyc++;
    end
    dump = 1'b0; out_ready = 1'b0;
    chk("words", k, 4);
    if (!stall) chk("busy_cycles", busy_n, 4);
    chk("in_ready_after", in_ready, 1);
    chk("busy_after", busy, 0);
    chk("out_valid_after", out_valid, 0);
  endtask
  initial begin
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_last", out_last, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    do_op(2, 3'd3, 8'd100);
    do_op(2, 3'd1, 8'hE2);
    do_op(2, 3'd2, 8'd5);
    run_dump(0, 0, 0, 65, 0, 0, 0);
    do_op(0, 3'd3, 8'd120);
    do_op(0, 3'd1, 8'd10);
    chk("ovf_add", ovf, 4'b0001);
    run_dump(0, E_ADD, 0, 65, 0, 0, 0);
    do_op(0, 3'd3, 8'd0);
    chk("ovf_load_clr", ovf, 4'b0000);
    do_op(1, 3'd3, 8'h80);
    do_op(1, 3'd4, 8'h33);
    chk("ovf_abs", ovf, 4'b0010);
    run_dump(0, 0, E_ABS, 65, 0, 0, 0);
    do_op(1, 3'd3, 8'hFB);
    do_op(1, 3'd4, 8'h00);
    chk("ovf_abs_ok", ovf, 4'b0000);
    do_op(3, 3'd3, 8'h80);
    do_op(3, 3'd2, 8'd1);
    chk("ovf_sub", ovf, 4'b1000);
    do_op(2, 3'd6, 8'd9);
    do_op(2, 3'd0, 8'd9);
    run_dump(0, 0, 5, 65, E_SUB, 0, 0);
    do_op(3, 3'd5, 8'd0);
    chk("ovf_clear_op", ovf, 4'b0000);
    do_op(2, 3'd1, 8'd100);
    chk("ovf_add2", ovf, 4'b0100);
    run_dump(1, 0, 5, E_ADD2, 0, 1, 0);
    chk("ovf_after_clr", ovf, 4'b0000);
    run_dump(0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b1; in_ch = 3; in_op = 3'd1; in_data = 8'd7;
    run_dump(0, 0, 0, 0, 7, 0, 1);
    dump = 1'b1;
    @(posedge clk); #1;
    dump = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_ch", out_ch, 2);
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_ch", out_ch, 0);
    chk("arst_out_last", out_last, 0);
    chk("arst_in_ready", in_ready, 1);
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_busy", busy, 0);
    run_dump(0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
